// File: rtl/axi_read_data_channel_pkg.sv
// Shared definitions for the AXI read data channel: default geometry,
// RRESP codes and the constant log2 helper used to size counters.
`timescale 1ns/1ps
package axi_read_data_channel_pkg;

  localparam int C_M_AXI_BURST_LEN  = 16;
  localparam int C_M_AXI_DATA_WIDTH = 64;
  localparam int RD_BUF_DEPTH       = 64;

  typedef enum logic [1:0] {
    RRESP_OKAY   = 2'b00,
    RRESP_EXOKAY = 2'b01,
    RRESP_SLVERR = 2'b10,
    RRESP_DECERR = 2'b11
  } rresp_e;

  // Number of bits needed to index 'value' entries (ceil(log2(value))).
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_read_data_channel_rd_data_fifo.sv
// First-word-fall-through synchronous circular buffer. The head entry is
// presented combinationally whenever the buffer is non-empty; pushes at full
// and pops at empty are ignored.
`timescale 1ns/1ps
module axi_read_data_channel_rd_data_fifo
  import axi_read_data_channel_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   pop_data,
  output logic [clogb2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = clogb2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  // Empty buffer shows zero so the output is clean out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage array: written on accepted pushes only, never reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_read_data_channel.sv
// AXI read data channel: buffers R beats, streams them out FWFT, and issues
// burst requests only when a whole burst of buffer space is guaranteed.
// Also checks RLAST framing and RRESP with sticky error flags.
// Optional macro AXI_RD_ERR_CNT_EN adds a saturating 16-bit error counter.
//
// Handshakes: a beat transfers when M_AXI_RVALID && M_AXI_RREADY at a rising
// edge; an output word transfers when dout_valid && dout_ready at a rising
// edge. Neither ready depends combinationally on its own valid.
`timescale 1ns/1ps
module axi_read_data_channel
  import axi_read_data_channel_pkg::*;
#(
  parameter int BURST_LEN  = C_M_AXI_BURST_LEN,
  parameter int DATA_WIDTH = C_M_AXI_DATA_WIDTH,
  parameter int BUF_DEPTH  = RD_BUF_DEPTH
) (
  input  logic                        M_AXI_ACLK,
  input  logic                        M_AXI_ARESET,
  input  logic                        rd_req_en,
  output logic                        rd_en,
  input  logic                        ar_hs,
  input  logic [DATA_WIDTH-1:0]       M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RLAST,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY,
  output logic [DATA_WIDTH-1:0]       dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic [clogb2(BUF_DEPTH):0]  buf_count,
  input  logic                        err_clr,
  output logic                        rresp_err,
  output logic                        rlast_err
`ifdef AXI_RD_ERR_CNT_EN
  ,
  output logic [15:0]                 err_cnt
`endif
);

  localparam int CW = clogb2(BUF_DEPTH) + 1;
  localparam int BW = clogb2(BURST_LEN);
  localparam logic [CW-1:0] BURST_CREDIT = CW'(BURST_LEN);
  localparam logic [CW-1:0] DEPTH_CREDIT = CW'(BUF_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT    = BW'(BURST_LEN - 1);

  logic          full;
  logic          empty;
  logic          beat;
  logic          pop;
  logic [CW-1:0] reserved;
  logic [CW-1:0] free;
  logic          rd_en_pending;
  logic          rd_en_set;
  logic [BW-1:0] beat_cnt;
  logic          at_last;
  logic          frame_err;
  logic          resp_err;

  // Ready comes from registered occupancy only; held low while in reset.
  assign M_AXI_RREADY = !full && !M_AXI_ARESET;
  assign beat         = M_AXI_RVALID && M_AXI_RREADY;
  assign dout_valid   = !empty;
  assign pop          = dout_valid && dout_ready;

  // Space not yet spoken for by stored beats or by granted bursts in flight.
  assign free      = DEPTH_CREDIT - buf_count - reserved;
  assign rd_en_set = rd_req_en && (free >= BURST_CREDIT) && !rd_en_pending;

  assign at_last   = (beat_cnt == LAST_BEAT);
  assign frame_err = beat && (M_AXI_RLAST != at_last);
  assign resp_err  = beat && (M_AXI_RRESP != RRESP_OKAY);

  axi_read_data_channel_rd_data_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_rd_data_fifo (
    .clk       (M_AXI_ACLK),
    .rst       (M_AXI_ARESET),
    .push      (beat),
    .push_data (M_AXI_RDATA),
    .pop       (pop),
    .pop_data  (dout),
    .count     (buf_count),
    .full      (full),
    .empty     (empty)
  );

  // Credits: a granted address reserves a burst, each arriving beat returns one.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) reserved <= '0;
    else              reserved <= reserved + (ar_hs ? BURST_CREDIT : '0) - CW'(beat);
  end

  // Single-cycle request pulse; one outstanding request until the address handshake.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      rd_en         <= 1'b0;
      rd_en_pending <= 1'b0;
    end else begin
      rd_en <= rd_en_set;
      if (rd_en_set)  rd_en_pending <= 1'b1;
      else if (ar_hs) rd_en_pending <= 1'b0;
    end
  end

  // Beat position within the burst; any RLAST or expected-last beat restarts framing.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET)                     beat_cnt <= '0;
    else if (beat && (M_AXI_RLAST || at_last)) beat_cnt <= '0;
    else if (beat)                        beat_cnt <= beat_cnt + BW'(1);
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      rresp_err <= 1'b0;
      rlast_err <= 1'b0;
    end else begin
      if (resp_err)     rresp_err <= 1'b1;
      else if (err_clr) rresp_err <= 1'b0;
      if (frame_err)    rlast_err <= 1'b1;
      else if (err_clr) rlast_err <= 1'b0;
    end
  end

`ifdef AXI_RD_ERR_CNT_EN
  logic [16:0] err_sum;
  logic [1:0]  err_inc;

  assign err_inc = {1'b0, frame_err} + {1'b0, resp_err};
  assign err_sum = {1'b0, err_cnt} + 17'(err_inc);

  // Saturating error count; errors in the clearing cycle are still counted.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET)  err_cnt <= '0;
    else if (err_clr)  err_cnt <= 16'(err_inc);
    else if (err_sum[16]) err_cnt <= 16'hFFFF;
    else               err_cnt <= err_sum[15:0];
  end
`endif

  // Stored beats plus reserved credits must never exceed the buffer.
  assert property (@(posedge M_AXI_ACLK) disable iff (M_AXI_ARESET)
    ((CW+1)'(buf_count) + (CW+1)'(reserved)) <= (CW+1)'(BUF_DEPTH));

  // A beat must always be covered by a reserved credit.
  assert property (@(posedge M_AXI_ACLK) disable iff (M_AXI_ARESET)
    beat |-> (reserved != '0));

endmodule

// File: tb/tb_axi_read_data_channel.sv
// Directed bench for axi_read_data_channel: reset, single burst, fill to
// capacity, drain with credit return, framing and RRESP errors, reset mid-burst.
`timescale 1ns/1ps
module tb_axi_read_data_channel;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_req_en = 1'b0;
  logic          rd_en;
  logic          ar_hs = 1'b0;
  logic [DW-1:0] M_AXI_RDATA = '0;
  logic [1:0]    M_AXI_RRESP = 2'b00;
  logic          M_AXI_RLAST = 1'b0;
  logic          M_AXI_RVALID = 1'b0;
  logic          M_AXI_RREADY;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic [6:0]    buf_count;
  logic          err_clr = 1'b0;
  logic          rresp_err;
  logic          rlast_err;
`ifdef AXI_RD_ERR_CNT_EN
  logic [15:0]   err_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  axi_read_data_channel dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .rd_req_en    (rd_req_en),
    .rd_en        (rd_en),
    .ar_hs        (ar_hs),
    .M_AXI_RDATA  (M_AXI_RDATA),
    .M_AXI_RRESP  (M_AXI_RRESP),
    .M_AXI_RLAST  (M_AXI_RLAST),
    .M_AXI_RVALID (M_AXI_RVALID),
    .M_AXI_RREADY (M_AXI_RREADY),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .buf_count    (buf_count),
    .err_clr      (err_clr),
    .rresp_err    (rresp_err),
`ifdef AXI_RD_ERR_CNT_EN
    .err_cnt      (err_cnt),
`endif
    .rlast_err    (rlast_err)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every output pop must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_data: got %0h, required no pop (queue empty)", dout);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (dout !== e) $display("FAIL pop_data: got %0h, required %0h", dout, e);
        else n_pass++;
      end
    end
  end

  // Driver tasks
  task automatic do_reset();
    rst = 1'b1;
    rd_req_en = 0; ar_hs = 0; M_AXI_RVALID = 0; M_AXI_RLAST = 0;
    M_AXI_RRESP = 2'b00; dout_ready = 0; err_clr = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic request_burst(output bit ok);
    ok = 0;
    rd_req_en = 1;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(posedge clk); #1;
      if (rd_en) ok = 1;
    end
    rd_req_en = 0;
    if (ok) begin
      ar_hs = 1;
      @(posedge clk); #1;
      ar_hs = 0;
    end
  endtask

  task automatic send_burst(input int n, input int last_at, input int bad_at,
                            input int clr_at, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      M_AXI_RVALID = 1;
      M_AXI_RDATA  = base + DW'(i);
      M_AXI_RLAST  = (i == last_at);
      M_AXI_RRESP  = (i == bad_at) ? 2'b10 : 2'b00;
      err_clr      = (i == clr_at);
      exp_q.push_back(base + DW'(i));
      @(posedge clk); #1;
    end
    M_AXI_RVALID = 0; M_AXI_RLAST = 0; M_AXI_RRESP = 2'b00; err_clr = 0;
  endtask

  // Tests
  task automatic test_reset();
    @(posedge clk); #1;
    n_checks++; if ({rd_en, M_AXI_RREADY, dout_valid, rresp_err, rlast_err} !== 5'b0)
      $display("FAIL reset_flags: got %b, required 00000", {rd_en, M_AXI_RREADY, dout_valid, rresp_err, rlast_err});
    else n_pass++;
    n_checks++; if (dout !== '0 || buf_count !== '0)
      $display("FAIL reset_data: got dout=%0h count=%0d, required 0/0", dout, buf_count);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (M_AXI_RREADY !== 1'b1 || rd_en !== 1'b0)
      $display("FAIL reset_release: got rready=%b rd_en=%b, required 1/0", M_AXI_RREADY, rd_en);
    else n_pass++;
  endtask

  task automatic test_single_burst();
    dout_ready = 1;
    rd_req_en = 1;
    @(posedge clk); #1;
    n_checks++; if (rd_en !== 1'b1) $display("FAIL sb_rd_en: got %b, required 1", rd_en);
    else n_pass++;
    rd_req_en = 0;
    ar_hs = 1;
    @(posedge clk); #1;
    ar_hs = 0;
    n_checks++; if (rd_en !== 1'b0) $display("FAIL sb_rd_en_pulse: got %b, required 0", rd_en);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (M_AXI_RREADY !== 1'b1) $display("FAIL sb_rready beat %0d: got 0, required 1", i);
      else n_pass++;
      M_AXI_RVALID = 1;
      M_AXI_RDATA  = 64'h1000 + DW'(i);
      M_AXI_RLAST  = (i == 15);
      exp_q.push_back(64'h1000 + DW'(i));
      @(posedge clk); #1;
      n_checks++; if (dout_valid !== 1'b1 || dout !== 64'h1000 + DW'(i))
        $display("FAIL sb_latency beat %0d: got v=%b d=%0h, required v=1 d=%0h", i, dout_valid, dout, 64'h1000 + DW'(i));
      else n_pass++;
    end
    M_AXI_RVALID = 0; M_AXI_RLAST = 0;
    @(posedge clk); #1;
    n_checks++; if (dout_valid !== 1'b0 || buf_count !== '0)
      $display("FAIL sb_empty: got v=%b count=%0d, required 0/0", dout_valid, buf_count);
    else n_pass++;
    n_checks++; if (rresp_err !== 1'b0 || rlast_err !== 1'b0)
      $display("FAIL sb_errors: got rresp=%b rlast=%b, required 0/0", rresp_err, rlast_err);
    else n_pass++;
  endtask

  task automatic test_fill();
    int req_cnt, beats_left, beat_in, drop_seen, sent;
    bit ack_owed;
    req_cnt = 0; beats_left = 0; beat_in = 0; drop_seen = 0; sent = 0; ack_owed = 0;
    do_reset();
    dout_ready = 0;
    rd_req_en = 1;
    for (int c = 0; c < 110; c++) begin
      @(posedge clk); #1;
      ar_hs = 0; M_AXI_RVALID = 0; M_AXI_RLAST = 0;
      if (rd_en) begin req_cnt++; ack_owed = 1; end
      if (beats_left > 0) begin
        if (!M_AXI_RREADY) drop_seen++;
        M_AXI_RVALID = 1;
        M_AXI_RDATA  = 64'h2000_0000 + DW'(sent);
        M_AXI_RLAST  = (beat_in == 15);
        exp_q.push_back(64'h2000_0000 + DW'(sent));
        sent++;
        beat_in = (beat_in + 1) % 16;
        beats_left--;
      end
      if (ack_owed) begin ar_hs = 1; ack_owed = 0; beats_left += 16; end
    end
    n_checks++; if (req_cnt !== 4) $display("FAIL fill_requests: got %0d, required 4", req_cnt);
    else n_pass++;
    n_checks++; if (drop_seen !== 0) $display("FAIL fill_rready_drop: got %0d drops, required 0", drop_seen);
    else n_pass++;
    n_checks++; if (buf_count !== 7'd64 || M_AXI_RREADY !== 1'b0 || rd_en !== 1'b0)
      $display("FAIL fill_full: got count=%0d rready=%b rd_en=%b, required 64/0/0", buf_count, M_AXI_RREADY, rd_en);
    else n_pass++;
  endtask

  task automatic test_drain();
    dout_ready = 1;
    repeat (16) begin @(posedge clk); #1; end
    dout_ready = 0;
    n_checks++; if (buf_count !== 7'd48 || rd_en !== 1'b0)
      $display("FAIL drain_16: got count=%0d rd_en=%b, required 48/0", buf_count, rd_en);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (rd_en !== 1'b1) $display("FAIL drain_reassert: got %b, required 1", rd_en);
    else n_pass++;
    ar_hs = 1; dout_ready = 1;
    @(posedge clk); #1;
    ar_hs = 0; dout_ready = 0;
    n_checks++; if (buf_count !== 7'd47 || rd_en !== 1'b0)
      $display("FAIL drain_hs_pop: got count=%0d rd_en=%b, required 47/0", buf_count, rd_en);
    else n_pass++;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (rd_en !== 1'b0) $display("FAIL drain_no_credit: got %b, required 0", rd_en);
    else n_pass++;
    dout_ready = 1;
    repeat (15) begin @(posedge clk); #1; end
    dout_ready = 0;
    n_checks++; if (buf_count !== 7'd32 || rd_en !== 1'b0)
      $display("FAIL drain_32: got count=%0d rd_en=%b, required 32/0", buf_count, rd_en);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (rd_en !== 1'b1) $display("FAIL drain_exact_credit: got %b, required 1", rd_en);
    else n_pass++;
  endtask

  task automatic test_rlast_err();
    bit ok;
    do_reset();
    dout_ready = 1;
    request_burst(ok);
    n_checks++; if (!ok) $display("FAIL rl_req1: got rd_en 0 for 8 cycles, required 1"); else n_pass++;
    send_burst(10, 9, -1, -1, 64'h4000);
    n_checks++; if (rlast_err !== 1'b1 || rresp_err !== 1'b0)
      $display("FAIL rl_early: got rlast=%b rresp=%b, required 1/0", rlast_err, rresp_err);
    else n_pass++;
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    n_checks++; if (rlast_err !== 1'b0) $display("FAIL rl_clear: got %b, required 0", rlast_err);
    else n_pass++;
    request_burst(ok);
    n_checks++; if (!ok) $display("FAIL rl_req2: got rd_en 0 for 8 cycles, required 1"); else n_pass++;
    send_burst(16, 15, -1, -1, 64'h4100);
    @(posedge clk); #1;
    n_checks++; if (rlast_err !== 1'b0 || exp_q.size() != 0)
      $display("FAIL rl_clean_after: got rlast=%b left=%0d, required 0/0", rlast_err, exp_q.size());
    else n_pass++;
    request_burst(ok);
    n_checks++; if (!ok) $display("FAIL rl_req3: got rd_en 0 for 8 cycles, required 1"); else n_pass++;
    send_burst(16, -1, -1, -1, 64'h4200);
    n_checks++; if (rlast_err !== 1'b1) $display("FAIL rl_missing: got %b, required 1", rlast_err);
    else n_pass++;
`ifdef AXI_RD_ERR_CNT_EN
    n_checks++; if (err_cnt !== 16'd1) $display("FAIL rl_err_cnt: got %0d, required 1", err_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_rresp_err();
    bit ok;
    do_reset();
    dout_ready = 1;
    request_burst(ok);
    n_checks++; if (!ok) $display("FAIL rr_req1: got rd_en 0 for 8 cycles, required 1"); else n_pass++;
    send_burst(16, 15, 2, -1, 64'h5000);
    @(posedge clk); #1;
    n_checks++; if (rresp_err !== 1'b1 || rlast_err !== 1'b0 || exp_q.size() != 0)
      $display("FAIL rr_flag: got rresp=%b rlast=%b left=%0d, required 1/0/0", rresp_err, rlast_err, exp_q.size());
    else n_pass++;
`ifdef AXI_RD_ERR_CNT_EN
    n_checks++; if (err_cnt !== 16'd1) $display("FAIL rr_err_cnt: got %0d, required 1", err_cnt);
    else n_pass++;
`endif
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0;
    n_checks++; if (rresp_err !== 1'b0) $display("FAIL rr_clear: got %b, required 0", rresp_err);
    else n_pass++;
    request_burst(ok);
    n_checks++; if (!ok) $display("FAIL rr_req2: got rd_en 0 for 8 cycles, required 1"); else n_pass++;
    send_burst(16, 15, 5, 5, 64'h5100);
    n_checks++; if (rresp_err !== 1'b1) $display("FAIL rr_set_wins: got %b, required 1", rresp_err);
    else n_pass++;
`ifdef AXI_RD_ERR_CNT_EN
    n_checks++; if (err_cnt !== 16'd1) $display("FAIL rr_cnt_set_wins: got %0d, required 1", err_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    do_reset();
    dout_ready = 0;
    request_burst(ok);
    n_checks++; if (!ok) $display("FAIL rm_req: got rd_en 0 for 8 cycles, required 1"); else n_pass++;
    send_burst(6, -1, 1, -1, 64'h6000);
    n_checks++; if (buf_count !== 7'd6 || rresp_err !== 1'b1)
      $display("FAIL rm_pre: got count=%0d rresp=%b, required 6/1", buf_count, rresp_err);
    else n_pass++;
    M_AXI_RVALID = 1; M_AXI_RDATA = 64'h6006;
    #3 rst = 1'b1;
    #1;
    n_checks++; if ({rd_en, M_AXI_RREADY, dout_valid, rresp_err, rlast_err} !== 5'b0)
      $display("FAIL rm_flags: got %b, required 00000", {rd_en, M_AXI_RREADY, dout_valid, rresp_err, rlast_err});
    else n_pass++;
    n_checks++; if (buf_count !== '0 || dout !== '0)
      $display("FAIL rm_data: got count=%0d dout=%0h, required 0/0", buf_count, dout);
    else n_pass++;
    M_AXI_RVALID = 0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_single_burst();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_fill();
    test_drain();
    test_rlast_err();
    test_rresp_err();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
